// File: rtl/uhci_frame_timer_pkg.sv
// rtl/uhci_frame_timer_pkg.sv - shared states and default timing for the UHCI frame timer
package uhci_frame_timer_pkg;

    typedef enum logic [1:0] {
        HALTED   = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_e;

    localparam int FRAME_BASE_DEF     = 11936;
    localparam int SOFMOD_DEFAULT_DEF = 64;
    localparam int PRESOF_TIME_DEF    = 256;

endpackage

// File: rtl/uhci_frame_timer_if.sv
// rtl/uhci_frame_timer_if.sv - register-file and SIE/list-processor signals of the frame timer
interface uhci_frame_timer_if #(
    parameter int FNUM_W   = 11,
    parameter int FLIST_W  = 10,
    parameter int SOFMOD_W = 7
);
    logic                RS;
    logic                TD_done;
    logic [SOFMOD_W-1:0] sofmod;
    logic                frnum_load;
    logic [FNUM_W-1:0]   frnum_in;
    logic                HCR_halt_sof;
    logic                sof;
    logic                pre_sof;
    logic [FNUM_W-1:0]   frame_num_SIE;
    logic [FLIST_W-1:0]  f_no;
    logic                f_rollover;

    modport master (
        output RS, TD_done, sofmod, frnum_load, frnum_in,
        input  HCR_halt_sof, sof, pre_sof, frame_num_SIE, f_no, f_rollover
    );

    modport slave (
        input  RS, TD_done, sofmod, frnum_load, frnum_in,
        output HCR_halt_sof, sof, pre_sof, frame_num_SIE, f_no, f_rollover
    );
endinterface

// File: rtl/uhci_frame_timer.sv
// rtl/uhci_frame_timer.sv - SOF strobe, pre-SOF window, frame number and run/stop/halt sequencing
module uhci_frame_timer
    import uhci_frame_timer_pkg::*;
#(
    parameter int FNUM_W         = 11,
    parameter int FLIST_W        = 10,
    parameter int CNT_W          = 14,
    parameter int FRAME_BASE     = FRAME_BASE_DEF,
    parameter int SOFMOD_W       = 7,
    parameter int SOFMOD_DEFAULT = SOFMOD_DEFAULT_DEF,
    parameter int PRESOF_TIME    = PRESOF_TIME_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    uhci_frame_timer_if.slave   tmr_if
);

    localparam logic [CNT_W-1:0] BASE_C    = CNT_W'(FRAME_BASE);
    localparam logic [CNT_W-1:0] PRESOF_C  = CNT_W'(PRESOF_TIME);
    localparam logic [CNT_W-1:0] LEN_RST_C = CNT_W'(FRAME_BASE + SOFMOD_DEFAULT);

    function automatic logic [CNT_W-1:0] len_for(input logic [SOFMOD_W-1:0] mod);
        return BASE_C + CNT_W'(mod);
    endfunction

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  frame_len_q, frame_len_d;
    logic [FNUM_W-1:0] fnum_q, fnum_d;
    logic              roll_q, roll_d;
    logic              active;
    logic              frame_end;

    assign active    = (state_q == RUN) || (state_q == STOPPING);
    assign frame_end = (cnt_q == frame_len_q - CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HALTED;
            cnt_q       <= '0;
            frame_len_q <= LEN_RST_C;
            fnum_q      <= '0;
            roll_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frame_len_q <= frame_len_d;
            fnum_q      <= fnum_d;
            roll_q      <= roll_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        frame_len_d = frame_len_q;
        fnum_d      = fnum_q;
        roll_d      = 1'b0;
        case (state_q)
            HALTED: begin
                cnt_d = '0;
                if (tmr_if.frnum_load) fnum_d = tmr_if.frnum_in;
                if (tmr_if.RS) begin
                    state_d     = RUN;
                    frame_len_d = len_for(tmr_if.sofmod);
                end
            end
            RUN, STOPPING: begin
                // sofmod is sampled only at frame end so a mid-frame write shapes the next frame
                if (frame_end) begin
                    cnt_d       = '0;
                    fnum_d      = fnum_q + FNUM_W'(1);
                    frame_len_d = len_for(tmr_if.sofmod);
                    roll_d      = &fnum_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (state_q == RUN) begin
                    if (!tmr_if.RS) state_d = STOPPING;
                end else if (tmr_if.RS) begin
                    state_d = RUN;
                end else if (tmr_if.TD_done) begin
                    // halting overrides any frame-end increment on the same edge
                    state_d = HALTED;
                    cnt_d   = '0;
                    fnum_d  = fnum_q;
                    roll_d  = 1'b0;
                end
            end
            default: state_d = HALTED;
        endcase
    end

    assign tmr_if.HCR_halt_sof  = !active;
    assign tmr_if.sof           = active && (cnt_q == '0);
    assign tmr_if.pre_sof       = active && (cnt_q >= frame_len_q - PRESOF_C);
    assign tmr_if.frame_num_SIE = fnum_q;
    assign tmr_if.f_no          = fnum_q[FLIST_W-1:0];
    assign tmr_if.f_rollover    = roll_q;

endmodule
